regfile_hilo: RTL and testbench

Architectural state block of the five-stage MIPS pipeline: the 32×32-bit general register file plus the HI/LO multiply/divide registers. It sits directly downstream of the write-back stage and consumes its `wb_to_rf_bus` to commit results. It serves the decode stage through two combinational GPR read ports and one HI/LO read port, each with same-cycle write-through bypass.

---
 rtl/regfile_hilo.sv | 83 ++++++++
 tb/tb_regfile_hilo.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/regfile_hilo.sv
// Architectural state of the five-stage MIPS pipeline: 31 general registers plus HI/LO,
// committed from the write-back bus and read combinationally by decode with write-through bypass.

package regfile_hilo_pkg;
  localparam int unsigned WB_TO_RF_WD = 104;

  // Field order matches the write-back bus, MSB first.
  typedef struct packed {
    logic        hi_we;
    logic [31:0] hi_i;
    logic        lo_we;
    logic [31:0] lo_i;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } wb_to_rf_t;
endpackage

module regfile_hilo
  import regfile_hilo_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
  input  logic [4:0]             raddr1,
  output logic [31:0]            rdata1,
  input  logic [4:0]             raddr2,
  output logic [31:0]            rdata2,
  output logic [31:0]            hi_o,
  output logic [31:0]            lo_o
);

  wb_to_rf_t wb;
  assign wb = wb_to_rf_t'(wb_to_rf_bus);

  // $0 is hard-wired to zero, so it has no storage.
  logic [31:0] regs_q [1:31];
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        gpr_we;
  logic        rf_hit1, rf_hit2;

  assign gpr_we  = !rst && wb.rf_we && (wb.rf_waddr != 5'd0);
  assign rf_hit1 = !rst && wb.rf_we && (wb.rf_waddr == raddr1);
  assign rf_hit2 = !rst && wb.rf_we && (wb.rf_waddr == raddr2);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; a missing branch would infer a latch.
    hi_d = hi_q;
    lo_d = lo_q;
    if (!rst && wb.hi_we) hi_d = wb.hi_i;
    if (!rst && wb.lo_we) lo_d = wb.lo_i;
  end

  // Next-state doubles as the bypassed read value.
  assign hi_o = hi_d;
  assign lo_o = lo_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file is built from flops, so it can and must be cleared like any other state.
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (gpr_we) regs_q[wb.rf_waddr] <= wb.rf_wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (raddr1 != 5'd0) rdata1 = rf_hit1 ? wb.rf_wdata : regs_q[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 != 5'd0) rdata2 = rf_hit2 ? wb.rf_wdata : regs_q[raddr2];
  end

endmodule

// File: tb/tb_regfile_hilo.sv
// Bench for regfile_hilo: directed scenarios with literal expectations, then a randomized
// run compared every cycle against an array-based model of the architectural state.

module tb_regfile_hilo;
  import regfile_hilo_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus;
  logic [4:0]             raddr1, raddr2;
  logic [31:0]            rdata1, rdata2, hi_o, lo_o;
  wb_to_rf_t              bus;

  assign wb_to_rf_bus = bus;

  regfile_hilo dut (
    .clk          (clk),
    .rst          (rst),
    .wb_to_rf_bus (wb_to_rf_bus),
    .raddr1       (raddr1),
    .rdata1       (rdata1),
    .raddr2       (raddr2),
    .rdata2       (rdata2),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_hi, m_lo;
  bit          m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic wb_to_rf_t mk(input logic hw, input logic [31:0] hv,
                                   input logic lw, input logic [31:0] lv,
                                   input logic rw, input logic [4:0] wa,
                                   input logic [31:0] wd);
    wb_to_rf_t b;
    b.hi_we = hw; b.hi_i = hv; b.lo_we = lw; b.lo_i = lv;
    b.rf_we = rw; b.rf_waddr = wa; b.rf_wdata = wd;
    return b;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (!rst && bus.rf_we && bus.rf_waddr == a) return bus.rf_wdata;
    return m_regs[a];
  endfunction

  // Model compare on the falling edge, model commit on the rising edge.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("model rdata1", rdata1, exp_rd(raddr1));
      check("model rdata2", rdata2, exp_rd(raddr2));
      check("model hi_o", hi_o, (!rst && bus.hi_we) ? bus.hi_i : m_hi);
      check("model lo_o", lo_o, (!rst && bus.lo_we) ? bus.lo_i : m_lo);
    end
    @(posedge clk);
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_hi = 32'h0;
      m_lo = 32'h0;
      m_valid = 1'b1;
    end else begin
      if (bus.rf_we && bus.rf_waddr != 5'd0) m_regs[bus.rf_waddr] = bus.rf_wdata;
      if (bus.hi_we) m_hi = bus.hi_i;
      if (bus.lo_we) m_lo = bus.lo_i;
    end
  end

  task automatic apply(input wb_to_rf_t b, input logic [4:0] a1, input logic [4:0] a2,
                       input logic r);
    @(posedge clk);
    #1;
    bus = b; raddr1 = a1; raddr2 = a2; rst = r;
    @(negedge clk);
    #1;
  endtask

  initial begin
    wb_to_rf_t b;
    logic [4:0] a1, a2;

    rst = 1'b1; bus = '0; raddr1 = '0; raddr2 = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 32; i++) begin
      a1 = i[4:0];
      a2 = 5'(31 - i);
      apply('0, a1, a2, 1'b0);
      check("reset rdata1", rdata1, 32'h0);
      check("reset rdata2", rdata2, 32'h0);
      if (i == 0) begin
        check("reset hi_o", hi_o, 32'h0);
        check("reset lo_o", lo_o, 32'h0);
      end
    end

    apply(mk(0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF), 5'd5, 5'd0, 1'b0);
    check("bypass $5", rdata1, 32'hDEADBEEF);
    apply('0, 5'd5, 5'd0, 1'b0);
    check("stored $5", rdata1, 32'hDEADBEEF);

    apply(mk(0, 0, 0, 0, 1, 5'd0, 32'h12345678), 5'd0, 5'd0, 1'b0);
    check("$0 write p1", rdata1, 32'h0);
    check("$0 write p2", rdata2, 32'h0);
    apply('0, 5'd0, 5'd0, 1'b0);
    check("$0 after p1", rdata1, 32'h0);
    check("$0 after p2", rdata2, 32'h0);

    apply(mk(1, 32'h1, 1, 32'h2, 0, 0, 0), 5'd0, 5'd0, 1'b0);
    check("hilo bypass hi", hi_o, 32'h1);
    check("hilo bypass lo", lo_o, 32'h2);
    apply(mk(0, 0, 1, 32'h3, 0, 0, 0), 5'd0, 5'd0, 1'b0);
    check("mtlo hi", hi_o, 32'h1);
    check("mtlo lo", lo_o, 32'h3);

    apply(mk(0, 0, 0, 0, 1, 5'd7, 32'hA), 5'd7, 5'd7, 1'b0);
    check("b2b N p1", rdata1, 32'hA);
    check("b2b N p2", rdata2, 32'hA);
    apply(mk(0, 0, 0, 0, 1, 5'd7, 32'hB), 5'd7, 5'd7, 1'b0);
    check("b2b N+1 p1", rdata1, 32'hB);
    check("b2b N+1 p2", rdata2, 32'hB);

    apply(mk(0, 0, 0, 0, 1, 5'd3, 32'hFF), 5'd3, 5'd7, 1'b0);
    check("preload $3", rdata1, 32'hFF);
    apply(mk(1, 32'h9, 0, 0, 1, 5'd3, 32'h55), 5'd3, 5'd7, 1'b1);
    check("rst no bypass $3", rdata1, 32'hFF);
    check("rst no bypass hi", hi_o, 32'h1);
    apply(mk(1, 32'h9, 0, 0, 1, 5'd3, 32'h55), 5'd3, 5'd7, 1'b1);
    check("rst cleared $3", rdata1, 32'h0);
    check("rst cleared $7", rdata2, 32'h0);
    check("rst cleared hi", hi_o, 32'h0);
    apply('0, 5'd3, 5'd7, 1'b0);
    check("post-rst $3", rdata1, 32'h0);
    check("post-rst hi", hi_o, 32'h0);
    check("post-rst lo", lo_o, 32'h0);

    // Disabled fields carry X to show they never leak to an output.
    for (int n = 0; n < 10000; n++) begin
      b.rf_we    = ($urandom_range(3) != 0);
      b.rf_waddr = 5'($urandom);
      b.rf_wdata = b.rf_we ? $urandom : 'x;
      b.hi_we    = ($urandom_range(3) == 0);
      b.hi_i     = b.hi_we ? $urandom : 'x;
      b.lo_we    = ($urandom_range(3) == 0);
      b.lo_i     = b.lo_we ? $urandom : 'x;
      if ($urandom_range(7) == 0) b = '0;
      a1 = ($urandom_range(3) == 0) ? b.rf_waddr : 5'($urandom);
      a2 = ($urandom_range(3) == 0) ? a1 : 5'($urandom);
      apply(b, a1, a2, ($urandom_range(127) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
